// File: rtl/audio_tone_player.sv
// Square-wave tone player that stalls the CPU until a note finishes.
// Optional: define AUDIO_GAP_EN for a silent gap after each note.
module audio_tone_player #(
   parameter int PRESCALE   = 64,
   parameter int TICK_DIV   = 50000,
   parameter int GAP_CYCLES = 1000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_audioreg,
   input  logic       i_audioact,
   input  logic [7:0] i_note_in,
   input  logic [7:0] i_dur_in,
   output logic       o_continue,
   output logic       o_speaker,
   output logic       o_busy
);

   localparam int HPW = 8 + $clog2(PRESCALE);
   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
`ifdef AUDIO_GAP_EN
      S_GAP  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t         r_state;
   logic [7:0]     r_note;
   logic [7:0]     r_dur;
   logic [7:0]     r_note_s;
   logic [7:0]     r_dur_s;
   logic [HPW-1:0] r_hp;
   logic [TW-1:0]  r_tick;
   logic [7:0]     r_dcnt;
   logic           r_spk;
   logic           r_cont;

`ifdef AUDIO_GAP_EN
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   logic [GW-1:0]  r_gap;
`endif

   logic [HPW-1:0] w_hp_lim;
   logic           w_hp_wrap;
   logic           w_tick_wrap;
   logic [7:0]     w_dcnt_nx;
   logic           w_play_end;

   assign w_hp_lim    = HPW'(r_note_s) * HPW'(PRESCALE);
   assign w_hp_wrap   = (r_hp == w_hp_lim - HPW'(1));
   assign w_tick_wrap = (r_tick == TW'(TICK_DIV - 1));
   assign w_dcnt_nx   = r_dcnt + 8'd1;
   assign w_play_end  = w_tick_wrap && (w_dcnt_nx == r_dur_s);

   assign o_continue = r_cont;
   assign o_speaker  = r_spk;
   assign o_busy     = (r_state != S_IDLE);

   // Note/duration registers, loadable at any time.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_note <= 8'd0;
         r_dur  <= 8'd0;
      end else if (i_audioreg) begin
         r_note <= i_note_in;
         r_dur  <= i_dur_in;
      end
   end

   // Playback FSM with its counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= S_IDLE;
         r_note_s <= 8'd0;
         r_dur_s  <= 8'd0;
         r_hp     <= '0;
         r_tick   <= '0;
         r_dcnt   <= 8'd0;
         r_spk    <= 1'b0;
         r_cont   <= 1'b0;
`ifdef AUDIO_GAP_EN
         r_gap    <= '0;
`endif
      end else begin
         r_cont <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_audioact) begin
                  if (r_dur != 8'd0) begin
                     r_state  <= S_PLAY;
                     r_note_s <= r_note;
                     r_dur_s  <= r_dur;
                     r_hp     <= '0;
                     r_tick   <= '0;
                     r_dcnt   <= 8'd0;
                     r_spk    <= (r_note != 8'd0);
                  end else begin
                     r_state <= S_DONE;
                     r_cont  <= 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (!i_audioact) begin
                  r_state <= S_IDLE;
                  r_spk   <= 1'b0;
               end else if (w_play_end) begin
                  r_spk <= 1'b0;
`ifdef AUDIO_GAP_EN
                  r_state <= S_GAP;
                  r_gap   <= '0;
`else
                  r_state <= S_DONE;
                  r_cont  <= 1'b1;
`endif
               end else begin
                  if (w_tick_wrap) begin
                     r_tick <= '0;
                     r_dcnt <= w_dcnt_nx;
                  end else begin
                     r_tick <= r_tick + TW'(1);
                  end
                  if (r_note_s != 8'd0) begin
                     if (w_hp_wrap) begin
                        r_hp  <= '0;
                        r_spk <= ~r_spk;
                     end else begin
                        r_hp <= r_hp + HPW'(1);
                     end
                  end
               end
            end
`ifdef AUDIO_GAP_EN
            S_GAP: begin
               if (!i_audioact) begin
                  r_state <= S_IDLE;
               end else if (r_gap == GW'(GAP_CYCLES - 1)) begin
                  r_state <= S_DONE;
                  r_cont  <= 1'b1;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
`endif
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_tone_player.sv
// Directed bench for audio_tone_player with small timing parameters.
// Expected values are hand-derived from the clock-level behaviour.
module tb_audio_tone_player;

`ifdef AUDIO_GAP_EN
   localparam int GAPC = 4;
`else
   localparam int GAPC = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       audioreg;
   logic       audioact;
   logic [7:0] note_in;
   logic [7:0] dur_in;
   logic       cont;
   logic       spk;
   logic       busy;

   int n_chk;
   int n_fail;

   audio_tone_player #(
      .PRESCALE  (2),
      .TICK_DIV  (10),
      .GAP_CYCLES(4)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst_n),
      .i_audioreg(audioreg),
      .i_audioact(audioact),
      .i_note_in (note_in),
      .i_dur_in  (dur_in),
      .o_continue(cont),
      .o_speaker (spk),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] n, input logic [7:0] d);
      audioreg = 1'b1;
      note_in  = n;
      dur_in   = d;
      step();
      audioreg = 1'b0;
   endtask

   initial begin
      int pulses;
      int t1;
      int t2;
      n_chk    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      audioreg = 1'b0;
      audioact = 1'b0;
      note_in  = 8'd0;
      dur_in   = 8'd0;
      #3;
      chk("rst_spk", int'(spk), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cont", int'(cont), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("idle_busy", int'(busy), 0);

      // note=3 dur=2: 20 PLAY cycles, toggle every 6
      load(8'd3, 8'd2);
      audioact = 1'b1;
      for (int p = 1; p <= 20; p++) begin
         step();
         chk("a_spk", int'(spk), ((p - 1) / 6) % 2 == 0 ? 1 : 0);
         chk("a_cont", int'(cont), 0);
         chk("a_busy", int'(busy), 1);
      end
      for (int g = 0; g < GAPC; g++) begin
         step();
         chk("a_gap_spk", int'(spk), 0);
         chk("a_gap_cont", int'(cont), 0);
      end
      step();
      chk("a_done_cont", int'(cont), 1);
      chk("a_done_spk", int'(spk), 0);
      audioact = 1'b0;
      step();
      chk("a_after_cont", int'(cont), 0);
      chk("a_after_busy", int'(busy), 0);

      // rest note: silent for 10 cycles
      load(8'd0, 8'd1);
      audioact = 1'b1;
      for (int p = 1; p <= 10; p++) begin
         step();
         chk("b_spk", int'(spk), 0);
         chk("b_cont", int'(cont), 0);
      end
      for (int g = 0; g < GAPC; g++) step();
      step();
      chk("b_done_cont", int'(cont), 1);
      audioact = 1'b0;
      step();
      chk("b_after_cont", int'(cont), 0);

      // zero duration: straight to DONE
      load(8'd5, 8'd0);
      audioact = 1'b1;
      step();
      chk("c_cont", int'(cont), 1);
      chk("c_spk", int'(spk), 0);
      chk("c_busy", int'(busy), 1);
      audioact = 1'b0;
      step();
      chk("c_cont2", int'(cont), 0);
      chk("c_busy2", int'(busy), 0);

      // load and play in same cycle: snapshot is the old pair
      load(8'd2, 8'd1);
      audioreg = 1'b1;
      note_in  = 8'd0;
      dur_in   = 8'd0;
      audioact = 1'b1;
      step();
      audioreg = 1'b0;
      chk("s_busy", int'(busy), 1);
      chk("s_spk", int'(spk), 1);
      chk("s_cont", int'(cont), 0);
      audioact = 1'b0;
      step();
      chk("s_abort_busy", int'(busy), 0);

      // abort at PLAY cycle 5
      load(8'd1, 8'd3);
      audioact = 1'b1;
      for (int p = 1; p <= 5; p++) step();
      chk("d_busy_pre", int'(busy), 1);
      audioact = 1'b0;
      step();
      chk("d_busy", int'(busy), 0);
      chk("d_spk", int'(spk), 0);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (cont) pulses++;
      end
      chk("d_pulses", pulses, 0);
      chk("d_spk_end", int'(spk), 0);

      // note=1 dur=1: toggle every 2, optional gap, then DONE
      load(8'd1, 8'd1);
      audioact = 1'b1;
      for (int p = 1; p <= 10; p++) begin
         step();
         chk("e_spk", int'(spk), ((p - 1) / 2) % 2 == 0 ? 1 : 0);
      end
      for (int g = 0; g < GAPC; g++) begin
         step();
         chk("e_gap_spk", int'(spk), 0);
         chk("e_gap_busy", int'(busy), 1);
         chk("e_gap_cont", int'(cont), 0);
      end
      step();
      chk("e_done_cont", int'(cont), 1);

      // keep audioact high: back-to-back plays
      pulses = 0;
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (cont) begin
            pulses++;
            if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
         end
      end
      chk("f_pulses_ge2", int'(pulses >= 2), 1);
      chk("f_spacing", t2 - t1, 12 + GAPC);
      audioact = 1'b0;
      step();
      step();
      chk("f_idle", int'(busy), 0);

      // async reset mid-PLAY clears registers
      load(8'd3, 8'd2);
      audioact = 1'b1;
      step();
      step();
      chk("r_busy_pre", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r_spk", int'(spk), 0);
      chk("r_busy", int'(busy), 0);
      chk("r_cont", int'(cont), 0);
      audioact = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("r_idle", int'(busy), 0);
      audioact = 1'b1;
      step();
      chk("r_zero_cont", int'(cont), 1);
      chk("r_zero_spk", int'(spk), 0);
      audioact = 1'b0;
      step();
      chk("r_zero_cont2", int'(cont), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_tone_player.md
Name: audio_tone_player

Overview:
- Audio output stage directly downstream of the control unit.
- The control unit pulses `audioreg` to load a note/duration pair from the register-file read ports.
- The control unit then holds `audioact` high and stalls the PC until this block pulses `continue`.
- This block generates a square-wave tone on `speaker` for the programmed duration, then releases the CPU.

Parameters:
- PRESCALE, 64: clocks per note unit; half-period = note × PRESCALE clocks.
- TICK_DIV, 50000: clocks per duration unit.
- GAP_CYCLES, 1000: silent gap length in clocks; used only with AUDIO_GAP_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- audioreg, input, 1: load strobe; latch `note_in`/`dur_in` on this edge.
- audioact, input, 1: play request, level; held by the control unit while stalled.
- note_in, input, 8: note half-period code; 0 = rest (silence).
- dur_in, input, 8: duration in TICK_DIV units.
- continue, output, 1: one-cycle pulse; playback finished, PC may advance.
- speaker, output, 1: square-wave audio output.
- busy, output, 1: high in PLAY/GAP/DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE; note_r=0, dur_r=0; all counters 0; speaker=0, continue=0, busy=0.
- Load registers: `audioreg`=1 at a clock edge → note_r←note_in, dur_r←dur_in. Allowed in any state; does not affect a playback already in progress (playback uses snapshots).
- FSM states: IDLE, PLAY, GAP (only with the macro), DONE.
- IDLE:
  - audioact=1 and dur_r≠0 → PLAY. Snapshot note_s←note_r and dur_s←dur_r; clear the tick, duration and half-period counters; speaker←1 if note_r≠0, else 0.
  - audioact=1 and dur_r=0 → DONE directly (zero-length play).
  - audioact=1 and audioreg=1 in the same cycle → snapshot uses the OLD note_r/dur_r.
- PLAY:
  - Half-period counter counts 0..note_s×PRESCALE−1; speaker toggles on wrap. note_s=0 → speaker held 0.
  - Tick counter counts 0..TICK_DIV−1; on wrap the duration counter increments.
  - When the duration counter reaches dur_s → DONE (or GAP with the macro); speaker←0.
  - Total PLAY residency = dur_s×TICK_DIV cycles exactly.
  - audioact falls during PLAY → abort to IDLE next edge: speaker←0, no continue pulse, registers kept.
- DONE: continue=1 for exactly one cycle, then IDLE unconditionally.
- Back-to-back plays: if audioact is still (or again) high in IDLE after DONE, a new play starts. Minimum one IDLE cycle between plays.
- continue is registered; it is never high outside DONE.
- Counter widths: half-period ≥ 8 + clog2(PRESCALE) bits; tick ≥ clog2(TICK_DIV) bits; duration 8 bits. No overflow is possible: the product is computed at full width.
- busy is registered-equivalent from the state (busy = state≠IDLE).

Optional Feature:
- Macro: AUDIO_GAP_EN.
- Defined: PLAY completion enters GAP; speaker=0 for GAP_CYCLES clocks, then DONE. An audioact drop during GAP aborts to IDLE with no continue. This gives audible articulation between repeated notes.
- Undefined: the GAP state and its counter are absent; PLAY goes straight to DONE.

Test Plan (bench uses PRESCALE=2, TICK_DIV=10, GAP_CYCLES=4):
- Reset mid-PLAY: assert reset=0 asynchronously between edges → speaker=0, busy=0 and continue=0 immediately; state IDLE after release; note_r/dur_r read back 0 (next play with dur_r=0 pulses continue with no tone).
- Load note=3, dur=2, then hold audioact → speaker toggles every 6 clocks; PLAY lasts 20 clocks; continue high for 1 cycle at cycle 22 after audioact is sampled (IDLE→PLAY 1, PLAY 20, DONE 1); speaker=0 afterwards.
- note=0, dur=1 with audioact → speaker stays 0 for 10 clocks; single continue pulse.
- dur=0 with audioact → continue pulses on the 2nd edge; speaker never toggles.
- audioact dropped at PLAY cycle 5 → IDLE, no continue pulse over the next 50 cycles; speaker=0.
- With AUDIO_GAP_EN: note=1, dur=1 → 10 tone cycles, 4 silent cycles, then continue; audioact held through two plays → two continue pulses separated by ≥ 16 cycles.
